// File: rtl/fsm_pkg.sv
// Shared types and helpers for the five-state go/jump controller.
package fsm_pkg;

    // Fixed state encodings; encodings 5..7 are illegal and recover to S0.
    localparam logic [2:0] ENC_S0 = 3'd0;
    localparam logic [2:0] ENC_S1 = 3'd1;
    localparam logic [2:0] ENC_S2 = 3'd2;
    localparam logic [2:0] ENC_S3 = 3'd3;
    localparam logic [2:0] ENC_S4 = 3'd4;

    typedef enum logic [2:0] {
        S0 = ENC_S0,
        S1 = ENC_S1,
        S2 = ENC_S2,
        S3 = ENC_S3,
        S4 = ENC_S4
    } state_t;

    // y decode: high only in the jump/terminal region (S3, S4).
    // Illegal encodings fall outside both compares and therefore give 0.
    function automatic logic is_jump_region(state_t s);
        return (s == S3) || (s == S4);
    endfunction

endpackage

// File: rtl/fsm.sv
// Five-state Moore controller: go walks S0..S4, jump short-cuts to S3.
// y is decoded from the state register only, so inputs never reach y
// combinationally and y follows a causing input by exactly one clock.
module fsm
    import fsm_pkg::*;
(
    input  logic clk,
    input  logic reset,   // asynchronous, active-low
    input  logic go,
    input  logic jump,
    output logic y
);

    state_t state_q;
    state_t state_d;

    // State register with asynchronous clear to S0 while reset is low.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; jump is tested before go in every row that looks at both.
    // NOTE: state_d gets a default before the case so every path assigns it;
    // without that, a missing branch would infer a latch.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0: begin
                if (jump)    state_d = S3;
                else if (go) state_d = S1;
                else         state_d = S0;
            end
            S1: begin
                if (jump) state_d = S3;
                else      state_d = S2;
            end
            S2: state_d = S3;
            S3: begin
                if (jump) state_d = S3;
                else      state_d = S4;
            end
            S4: begin
                // go has no effect here: the run always ends back in S0.
                if (jump) state_d = S3;
                else      state_d = S0;
            end
            default: state_d = S0;  // illegal 5..7 recover in one clock
        endcase
    end

    assign y = is_jump_region(state_q);

endmodule

// File: tb/tb_fsm.sv
// Self-checking bench for fsm: directed scenarios plus randomized go/jump
// traffic compared against an arithmetic reference model.
module tb_fsm;
    import fsm_pkg::*;

    logic clk;
    logic reset;
    logic go;
    logic jump;
    logic y;

    int n_checks;
    int n_fail;
    int ref_st;   // reference state as a plain number 0..4

    fsm dut (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .jump  (jump),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got running, need finished)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference rules: jump always lands in 3; S0 waits for go; every other
    // state advances by one, wrapping 4 -> 0.
    function automatic int ref_next(input int st, input logic g, input logic j);
        if (j)        return 3;
        if (st == 0)  return g ? 1 : 0;
        return (st + 1) % 5;
    endfunction

    function automatic int ref_y(input int st);
        return (st >= 3) ? 1 : 0;
    endfunction

    // Apply inputs, take one rising edge, then compare y and state 1 time unit later.
    task automatic step(input string tag, input logic g, input logic j);
        go   = g;
        jump = j;
        @(posedge clk);
        ref_st = ref_next(ref_st, g, j);
        #1;
        check({tag, ".y"},     int'(y),             ref_y(ref_st));
        check({tag, ".state"}, int'(dut.state_q),   ref_st);
    endtask

    // Drive the DUT back to S0 through an asynchronous reset pulse.
    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        ref_st = 0;
        check("rst_pulse.y", int'(y), 0);
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ref_st   = 0;
        reset    = 1'b0;
        go       = 1'b1;
        jump     = 1'b1;

        // Reset held for two edges with both requests active.
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold.y",     int'(y),           0);
            check("reset_hold.state", int'(dut.state_q), 0);
        end
        reset = 1'b1;
        step("release_idle", 1'b0, 1'b0);

        // Normal run S1,S2,S3,S4,S0.
        for (int i = 0; i < 5; i++) step("normal_run", 1'b1, 1'b0);

        // Jump sequence.
        step("jseq_go",   1'b1, 1'b0);  // S1
        step("jseq_jump", 1'b0, 1'b1);  // S3
        step("jseq_rel",  1'b0, 1'b0);  // S4
        step("jseq_s4go", 1'b1, 1'b0);  // S0, go ignored
        check("jseq_end_s0", ref_st, 0);

        // Priority: both requests in S0 and in S1.
        step("prio_s0", 1'b1, 1'b1);    // S3
        step("to_s4",   1'b0, 1'b0);
        step("to_s0",   1'b0, 1'b0);
        step("to_s1",   1'b1, 1'b0);
        step("prio_s1", 1'b1, 1'b1);    // S3
        for (int i = 0; i < 3; i++) step("hold_s3", 1'b0, 1'b1);

        // Async reset from S4, between edges.
        step("to_s4b", 1'b0, 1'b0);
        check("async_pre.y", int'(y), 1);
        pulse_reset();
        check("async_post.state", int'(dut.state_q), 0);
        step("after_rst_go", 1'b1, 1'b0);  // S1

        // Illegal encoding recovery.
        go   = 1'b1;
        jump = 1'b0;
        force dut.state_q = state_t'(3'd6);
        #1;
        check("illegal.y_before", int'(y), 0);
        release dut.state_q;
        @(posedge clk);
        #1;
        ref_st = 0;
        check("illegal.state_after", int'(dut.state_q), 0);
        check("illegal.y_after",     int'(y),           0);

        // Randomized traffic with occasional mid-cycle async resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset();
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
